// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between instruction fetch (I)
// and load/store (D), with in-order response steering through a small ID FIFO.
`default_nettype none

module sram_req_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_orphan
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [OUTSTANDING-1:0] id_q;
  logic [PW-1:0]          head, tail;
  logic [2:0]             count;
  logic [2:0]             starve_cnt;
  logic                   full, empty, grant_i, grant_d, push, pop, head_is_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == 3'(OUTSTANDING));
  assign empty     = (count == 3'd0);
  assign head_is_d = id_q[head];

  // Grant is suppressed entirely in reset so no handshake can leak out.
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    if (resetn && !full) begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || starve_cnt == 3'(STARVE_MAX))) grant_i = 1'b1;
          else if (d_req)                                        grant_d = 1'b1;
          if ((grant_i || grant_d) && !mem_addr_ok)
            state_nxt = grant_i ? HOLD_I : HOLD_D;
        end
        HOLD_I: begin
          grant_i = 1'b1;
          if (mem_addr_ok && i_req) state_nxt = IDLE;
        end
        HOLD_D: begin
          grant_d = 1'b1;
          if (mem_addr_ok && d_req) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = (grant_i & i_req) | (grant_d & d_req);
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (grant_i) begin
      mem_wr    = i_wr;
      mem_size  = i_size;
      mem_wstrb = i_wstrb;
      mem_addr  = i_addr;
      mem_wdata = i_wdata;
    end else if (grant_d) begin
      mem_wr    = d_wr;
      mem_size  = d_size;
      mem_wstrb = d_wstrb;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign push      = mem_req & mem_addr_ok;
  assign pop       = mem_data_ok & ~empty;
  assign i_addr_ok = mem_addr_ok & grant_i & mem_req;
  assign d_addr_ok = mem_addr_ok & grant_d & mem_req;
  assign i_data_ok = pop & ~head_is_d;
  assign d_data_ok = pop & head_is_d;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      id_q       <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= 3'd0;
      starve_cnt <= 3'd0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        id_q[tail] <= grant_d;
        tail       <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // Saturate so the starvation threshold is always reachable for I.
      if (push && grant_i)
        starve_cnt <= 3'd0;
      else if (push && grant_d && i_req && starve_cnt != 3'(STARVE_MAX))
        starve_cnt <= starve_cnt + 3'd1;
      if (mem_data_ok && empty) err_orphan <= 1'b1;
    end
  end

endmodule

`default_nettype wire
